// File: rtl/serial_sub_pkg.sv
// Shared types and a reference model for the bit-serial subtractor.
package serial_sub_pkg;

  // Sequencer states: wait for a request, shift one bit per cycle, hold the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Widest operand the reference model handles.
  localparam int unsigned REF_MAX_W = 32;

  // Reference: returns {bo, d} with d in bits [width-1:0] and bo in bit [width].
  // Operands are assumed to fit in 'width' bits.
  function automatic logic [REF_MAX_W:0] ref_sub(
    input logic [REF_MAX_W-1:0] a,
    input logic [REF_MAX_W-1:0] b,
    input logic                 bi,
    input int unsigned          width
  );
    logic [REF_MAX_W:0] rhs;
    logic [REF_MAX_W:0] sub_full;
    logic [REF_MAX_W:0] res;
    rhs      = {1'b0, b} + {{REF_MAX_W{1'b0}}, bi};
    sub_full = {1'b0, a} - rhs;
    res      = '0;
    for (int i = 0; i < int'(REF_MAX_W); i++) begin
      if (i < int'(width)) begin
        res[i] = sub_full[i];
      end
    end
    res[width] = ({1'b0, a} < rhs);
    return res;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: D = A - B - BI, BO set when a borrow is needed.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic BO
);

  assign D  = A ^ B ^ BI;
  assign BO = (~A & B) | (~(A ^ B) & BI);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walks the operands
// LSB first, with valid/ready handshakes on the request and result sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BO
);

  // A one-bit counter is kept even for WIDTH == 1 so the compare stays legal.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] a_sh_q,      a_sh_d;
  logic [WIDTH-1:0] b_sh_q,      b_sh_d;
  logic             borrow_q,    borrow_d;
  logic [WIDTH-1:0] d_q,         d_d;
  logic             bo_q,        bo_d;
  logic             out_valid_q, out_valid_d;

  logic cell_d;
  logic cell_bo;

  full_subtractor u_cell (
    .A  (a_sh_q[0]),
    .B  (b_sh_q[0]),
    .BI (borrow_q),
    .D  (cell_d),
    .BO (cell_bo)
  );

  // Next-state logic: latch on accept, shift while busy, hold the result until taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    borrow_d    = borrow_q;
    d_d         = d_q;
    bo_d        = bo_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = A;
          b_sh_d   = B;
          borrow_d = BI;
          cnt_d    = '0;
          d_d      = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        // Result bits enter at the MSB so the LSB-first stream lands in place.
        d_d            = d_q >> 1;
        d_d[WIDTH-1]   = cell_d;
        a_sh_d         = a_sh_q >> 1;
        b_sh_d         = b_sh_q >> 1;
        borrow_d       = cell_bo;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bo_d        = cell_bo;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; a reset mid-operation discards everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      borrow_q    <= 1'b0;
      d_q         <= '0;
      bo_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      borrow_q    <= borrow_d;
      d_q         <= d_d;
      bo_q        <= bo_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign BO        = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 4 (directed + exhaustive) and WIDTH 1 / 8
// (randomised), with scoreboards fed on acceptance and drained on result handshake.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  typedef struct {
    logic       bo;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Every comparison goes through here.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Independent arithmetic model: signed difference, then wrap to w bits.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic bi);
    exp_t e;
    int   diff;
    diff = int'(a) - int'(b) - int'(bi);
    e.bo = (diff < 0);
    e.d  = 8'((diff + 512) & ((1 << w) - 1));
    return e;
  endfunction

  // ---------------- WIDTH = 4 instance ----------------
  logic       rst_n4     = 1'b0;
  logic       in_valid4  = 1'b0;
  logic       in_ready4;
  logic [3:0] a4         = '0;
  logic [3:0] b4         = '0;
  logic       bi4        = 1'b0;
  logic       out_valid4;
  logic       out_ready4;
  logic [3:0] d4;
  logic       bo4;
  logic       rand_or4   = 1'b0;
  logic       man_or4    = 1'b0;
  logic       rnd_or4    = 1'b0;
  exp_t       q4[$];

  assign out_ready4 = rand_or4 ? rnd_or4 : man_or4;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .A         (a4),
    .B         (b4),
    .BI        (bi4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .D         (d4),
    .BO        (bo4)
  );

  always @(posedge clk) begin
    #1 rnd_or4 = 1'($urandom_range(0, 1));
  end

  // Result side: the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n4 && out_valid4 && out_ready4) begin
      exp_t e;
      if (q4.size() > 0) e = q4.pop_front();
      else begin
        e.bo = 1'bx;
        e.d  = 8'hxx;
      end
      $display("txn w=4 d=%0h bo=%0b", d4, bo4);
      check("w4_sb_d", 64'(d4), 64'(e.d));
      check("w4_sb_bo", 64'(bo4), 64'(e.bo));
    end
  end

  // Presents a request until accepted; called #1 after a rising edge, returns likewise.
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic bi, output bit ok);
    bit acc;
    in_valid4 = 1'b1;
    a4 = a;
    b4 = b;
    bi4 = bi;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      acc = in_ready4;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    in_valid4 = 1'b0;
    if (ok) q4.push_back(model(4, 8'(a), 8'(b), bi));
    else check("w4_accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic wait_valid4();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (out_valid4) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) check("w4_valid_timeout", 64'(seen), 64'(1));
  endtask

  // One full directed transaction against fixed expected values.
  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bi,
                      input logic [3:0] exp_d, input logic exp_bo);
    bit ok;
    drive4(a, b, bi, ok);
    wait_valid4();
    check({tag, "_d"}, 64'(d4), 64'(exp_d));
    check({tag, "_bo"}, 64'(bo4), 64'(exp_bo));
    check({tag, "_ref"}, 64'(ref_sub(32'(a), 32'(b), bi, 4)), 64'({exp_bo, exp_d}));
    man_or4 = 1'b1;
    @(posedge clk);
    #1;
    man_or4 = 1'b0;
  endtask

  // ---------------- WIDTH = 1 and WIDTH = 8 instances ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_w
    localparam int W = (gi == 0) ? 1 : 8;
    localparam string TAG_D  = (gi == 0) ? "w1_sb_d" : "w8_sb_d";
    localparam string TAG_BO = (gi == 0) ? "w1_sb_bo" : "w8_sb_bo";

    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         bi        = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d;
    logic         bo;
    exp_t         q[$];
    bit           done_f    = 1'b0;

    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a),
      .B         (b),
      .BI        (bi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (d),
      .BO        (bo)
    );

    always @(posedge clk) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
        exp_t e;
        if (q.size() > 0) e = q.pop_front();
        else begin
          e.bo = 1'bx;
          e.d  = 8'hxx;
        end
        $display("txn w=%0d d=%0h bo=%0b", W, d, bo);
        check(TAG_D, 64'(d), 64'(e.d));
        check(TAG_BO, 64'(bo), 64'(e.bo));
      end
    end

    initial begin
      int         n_txn;
      logic [16:0] v;
      bit          ok;
      bit          acc;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      n_txn = (W == 1) ? 64 : 600;
      for (int i = 0; i < n_txn; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        v = (W == 1) ? 17'(i % 8) : 17'($urandom);
        a = v[W-1:0];
        b = v[2*W-1:W];
        bi = v[2*W];
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
          acc = in_ready;
          @(posedge clk);
          #1;
          if (acc) ok = 1'b1;
        end
        in_valid = 1'b0;
        if (ok) q.push_back(model(W, 8'(a), 8'(b), bi));
        else check(TAG_D, 64'(ok), 64'(1));
      end
      for (int n = 0; n < 500 && q.size() > 0; n++) @(posedge clk);
      check(TAG_D, 64'(q.size()), 64'(0));
      done_f = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit          ok;
    logic [3:0]  held_d;
    logic        held_bo;
    logic [8:0]  v;
    int          budget;

    // Reset state after the first reset edge.
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready4), 64'(1));
    check("rst_out_valid", 64'(out_valid4), 64'(0));
    check("rst_d", 64'(d4), 64'(0));
    check("rst_bo", 64'(bo4), 64'(0));
    @(posedge clk);
    #1 rst_n4 = 1'b1;

    // Basic subtraction with exact latency: valid appears after the 4th edge.
    drive4(4'd9, 4'd3, 1'b0, ok);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("lat_out_valid", 64'(out_valid4), 64'(k == 4));
    end
    check("basic_d", 64'(d4), 64'(6));
    check("basic_bo", 64'(bo4), 64'(0));
    check("basic_ref", 64'(ref_sub(32'd9, 32'd3, 1'b0, 4)), 64'(5'h06));
    man_or4 = 1'b1;
    @(posedge clk);
    #1;
    man_or4 = 1'b0;
    check("basic_idle", 64'(in_ready4), 64'(1));

    run4("wrap", 4'd3, 4'd9, 1'b0, 4'd10, 1'b1);
    run4("bi_zero", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
    run4("bi_exact", 4'd8, 4'd7, 1'b1, 4'd0, 1'b0);
    run4("bi_full", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1);

    // Reset on the third SHIFT cycle; BO still holds 1 from the previous result.
    drive4(4'd15, 4'd0, 1'b0, ok);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n4 = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid4), 64'(0));
    check("midrst_d", 64'(d4), 64'(0));
    check("midrst_bo", 64'(bo4), 64'(0));
    check("midrst_in_ready", 64'(in_ready4), 64'(1));
    q4.delete();
    rst_n4 = 1'b1;
    run4("after_rst", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0);

    // Backpressure: result held for 5 cycles, a new request pulse is ignored.
    drive4(4'd12, 4'd5, 1'b0, ok);
    wait_valid4();
    held_d  = 4'd7;
    held_bo = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        in_valid4 = 1'b1;
        a4 = 4'd1;
        b4 = 4'd1;
        bi4 = 1'b0;
      end
      if (k == 2) in_valid4 = 1'b0;
      check("bp_out_valid", 64'(out_valid4), 64'(1));
      check("bp_d", 64'(d4), 64'(held_d));
      check("bp_bo", 64'(bo4), 64'(held_bo));
      check("bp_in_ready", 64'(in_ready4), 64'(0));
      @(posedge clk);
      #1;
    end
    man_or4 = 1'b1;
    @(posedge clk);
    #1;
    man_or4 = 1'b0;
    check("bp_release_in_ready", 64'(in_ready4), 64'(1));
    check("bp_release_out_valid", 64'(out_valid4), 64'(0));
    check("bp_hold_d", 64'(d4), 64'(held_d));

    // Exhaustive 512 combinations with random gaps and random out_ready.
    rand_or4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      v = 9'(i);
      drive4(v[3:0], v[7:4], v[8], ok);
    end
    for (int n = 0; n < 500 && q4.size() > 0; n++) @(posedge clk);
    check("w4_drain", 64'(q4.size()), 64'(0));
    rand_or4 = 1'b0;

    budget = 0;
    while (!(g_w[0].done_f && g_w[1].done_f) && budget < 30000) begin
      @(posedge clk);
      budget++;
    end
    check("side_done", 64'(g_w[0].done_f && g_w[1].done_f), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor. It computes D = A − B − BI, one bit per clock, LSB first, through a single full-subtractor cell, and returns a borrow-out BO. It is the inverse-operation companion to the team's ripple-carry 4-bit adder, trading latency for one-cell area. It sits behind a valid/ready request and a valid/ready result, so it can be dropped between pipeline stages.

## Interface
- WIDTH, 4, operand and result width in bits; legal values ≥ 1.

- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  request strobe; A, B and BI are valid while it is high.
- in_ready  out  1  block can accept a request.
- A  in  WIDTH  minuend, unsigned.
- B  in  WIDTH  subtrahend, unsigned.
- BI  in  1  borrow-in.
- out_valid  out  1  D and BO hold a completed result.
- out_ready  in  1  consumer accepts the result.
- D  out  WIDTH  difference, (A − B − BI) mod 2^WIDTH.
- BO  out  1  borrow-out; 1 iff A < B + BI (unsigned).

## Operation
- **FSM states:** IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid && in_ready, the block latches A, B and BI into shift/borrow registers, clears the bit counter to 0, clears the D shift register, and moves to SHIFT.
- **SHIFT:**
  - Each cycle, bit a = A_sh[0], b = B_sh[0], bi = borrow register.
  - Cell outputs: d = a^b^bi and bo = (~a&b) | (~(a^b)&bi).
  - d is shifted into the D register from the MSB side. A_sh and B_sh shift right. The borrow register takes bo. The counter increments.
  - When counter == WIDTH−1, the block goes to DONE, D takes its final value, and BO takes the final bo.
- **DONE:**
  - out_valid = 1; D and BO are stable.
  - On out_ready, the block returns to IDLE.
- **in_ready** = (state == IDLE). in_valid in SHIFT or DONE is ignored; there is no queuing and no overlap of requests.
- **Output register holding:** D and BO are registers. They keep the last result after the out handshake, until the next request overwrites them. During SHIFT, D holds partial contents and is not valid.
- **Width rules:**
  - The counter is max(1, $clog2(WIDTH)) bits.
  - Arithmetic is unsigned modulo 2^WIDTH.
  - BI = 1 propagates as an initial borrow.

## Timing
- **Reset values** (rst_n low at an edge): state IDLE, out_valid 0, D 0, BO 0, counter 0, borrow 0. in_ready reads 1 after the first reset edge.
- **Reset mid-operation:** reset in SHIFT or DONE aborts the operation. The partial result is discarded, and the reset values apply at the next edge.
- **Latency:**
  - The request is accepted at edge T.
  - out_valid rises after edge T+WIDTH.
  - For WIDTH = 1, this is the edge after acceptance.
- **Throughput:** at most one result per WIDTH+2 cycles with out_ready held high. The DONE→IDLE edge and the IDLE acceptance edge are separate.
- **Backpressure:** out_valid, D and BO are stable while out_ready is low; the wait is unbounded.
- **Idle out_ready:** out_ready outside DONE has no effect.

## Structure
- **Package serial_sub_pkg** holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a reference function ref_sub(a, b, bi) returning {bo, d}, used by the bench and assertions.
- **Sub-module full_subtractor** (ports A, B, BI → D, BO): purely combinational, instantiated once.
- **Top level** holds the FSM, counter, shift registers, borrow register and output registers.

## Test plan
- **Basic subtraction:** reset, then A=9, B=3, BI=0 accepted → out_valid exactly 4 edges later with D=6, BO=0.
- **Wrap-around:** A=3, B=9, BI=0 → D=10, BO=1.
- **Borrow-in edge cases:**
  - A=0, B=0, BI=1 → D=15, BO=1.
  - A=8, B=7, BI=1 → D=0, BO=0.
  - A=15, B=15, BI=1 → D=15, BO=1.
- **Backpressure:** hold out_ready low for 5 cycles in DONE and pulse in_valid with new operands → D and BO unchanged, in_ready=0, pulse not accepted. Raise out_ready → IDLE next edge, in_ready=1.
- **Reset mid-operation:** assert rst_n low on the third SHIFT cycle → next edge out_valid=0, D=0, BO=0, IDLE. The next request A=5, B=2, BI=0 then gives D=3, BO=0.
- **Exhaustive check:** all 512 combinations of A, B, BI with randomized out_ready and in_valid gaps → every result matches ref_sub. Repeat the same check at WIDTH=1 and WIDTH=8.
